// File: rtl/chan_dump_if.sv
// Signal bundle between the channel dump block, the RAM read port,
// the UART transmitter and the command/config block.
interface chan_dump_if #(
  parameter int LOG2 = 9
);
  logic            dump_start;
  logic            capture_done;
  logic [LOG2-1:0] waddr_end;
  logic [7:0]      rdata;
  logic            tx_rdy;
  logic            ren;
  logic [LOG2-1:0] raddr;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            dumping;
  logic            dump_done;
  logic            dump_err;

  // Dump block side.
  modport master (
    input  dump_start, capture_done, waddr_end, rdata, tx_rdy,
    output ren, raddr, tx_data, trmt, dumping, dump_done, dump_err
  );

  // RAM / UART / command side.
  modport slave (
    output dump_start, capture_done, waddr_end, rdata, tx_rdy,
    input  ren, raddr, tx_data, trmt, dumping, dump_done, dump_err
  );
endinterface

// File: rtl/chan_dump.sv
// Dumps one channel's circular capture buffer oldest-first to the UART.
// Reads start at the final write address and wrap at ENTRIES; every
// byte goes through a READ/LATCH/SEND/HOLD cycle gated by tx_rdy.
module chan_dump #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic       clk,
  input  logic       rst,
  chan_dump_if.master bus
);

  localparam logic [LOG2:0]   ENT  = ENTRIES[LOG2:0];
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, HOLD, WAIT_TX} state_t;

  state_t        state;
  logic [LOG2:0] byte_cnt;

  // Dump sequencer; all outputs are registered, strobes default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      bus.raddr     <= '0;
      bus.tx_data   <= '0;
      bus.ren       <= 1'b0;
      bus.trmt      <= 1'b0;
      bus.dumping   <= 1'b0;
      bus.dump_done <= 1'b0;
      bus.dump_err  <= 1'b0;
    end else begin
      bus.ren       <= 1'b0;
      bus.trmt      <= 1'b0;
      bus.dump_done <= 1'b0;
      bus.dump_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dump_start) begin
            if (bus.capture_done) begin
              // An out-of-range end pointer cannot be an oldest sample; start at 0.
              bus.raddr   <= ({1'b0, bus.waddr_end} >= ENT) ? '0 : bus.waddr_end;
              byte_cnt    <= '0;
              bus.ren     <= 1'b1;
              bus.dumping <= 1'b1;
              state       <= READ;
            end else begin
              bus.dump_err <= 1'b1;
            end
          end
        end
        READ:  state <= LATCH;
        LATCH: begin
          bus.tx_data <= bus.rdata;
          state       <= SEND;
        end
        SEND: begin
          if (bus.tx_rdy) begin
            bus.trmt  <= 1'b1;
            bus.raddr <= (bus.raddr == LAST) ? '0 : bus.raddr + 1'b1;
            byte_cnt  <= byte_cnt + 1'b1;
            state     <= HOLD;
          end
        end
        // tx_rdy is still the pre-strobe value here, so it is not looked at.
        HOLD: begin
          if (byte_cnt == ENT) begin
            state <= WAIT_TX;
          end else begin
            bus.ren <= 1'b1;
            state   <= READ;
          end
        end
        WAIT_TX: begin
          if (bus.tx_rdy) begin
            bus.dump_done <= 1'b1;
            bus.dumping   <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_dump.sv
// Directed bench for chan_dump: RAM model with RAM[i]=i[7:0], UART model
// busy for 10 cycles after each strobe, monitor collecting bytes/addresses.
module tb_chan_dump;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chan_dump_if #(.LOG2(LOG2)) bus ();

  chan_dump #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscmp  = 0;

  // RAM model: registered read, data valid the cycle after ren.
  always @(posedge clk) if (bus.ren) bus.rdata <= bus.raddr[7:0];

  // UART model: tx_rdy drops the cycle after trmt and stays low 10 cycles.
  int  busy  = 0;
  logic stall = 1'b0;
  always @(posedge clk) begin
    if (bus.trmt) busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end
  assign bus.tx_rdy = (busy == 0) && !stall;

  // Monitor, sampled on the falling edge.
  logic [7:0]      bytes [$];
  logic [LOG2-1:0] addrs [$];
  int   done_cnt = 0, err_cnt = 0, viol = 0;
  logic prev_trmt = 1'b0;
  always @(negedge clk) begin
    if (bus.trmt) begin
      bytes.push_back(bus.tx_data);
      if (!bus.tx_rdy || prev_trmt) viol++;
    end
    if (bus.ren) addrs.push_back(bus.raddr);
    if (bus.dump_done) done_cnt++;
    if (bus.dump_err) err_cnt++;
    prev_trmt = bus.trmt;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    bytes.delete(); addrs.delete();
    done_cnt = 0; err_cnt = 0; viol = 0;
  endtask

  // Start a dump and check the first READ cycle one edge later.
  task automatic start_dump(input logic [LOG2-1:0] wend, input int exp_start);
    bus.waddr_end    = wend;
    bus.capture_done = 1'b1;
    bus.dump_start   = 1'b1;
    step();
    bus.dump_start   = 1'b0;
    check("start_ren", 32'(bus.ren), 1);
    check("start_raddr", 32'(bus.raddr), exp_start);
    check("start_dumping", 32'(bus.dumping), 1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (bytes.size() < n && k < budget) begin step(); k++; end
    check("bytes_timeout", (bytes.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin step(); k++; end
    check("done_timeout", (done_cnt > 0) ? 1 : 0, 1);
    step(); step();
    check("done_count", done_cnt, 1);
    check("dumping_end", 32'(bus.dumping), 0);
    check("protocol_viol", viol, 0);
  endtask

  // Compare the whole byte stream against an oldest-first read from start.
  task automatic check_stream(input string tag, input int start);
    int bad = 0;
    check({tag, "_len"}, bytes.size(), ENTRIES);
    for (int i = 0; i < bytes.size() && i < ENTRIES; i++) begin
      int a = (start + i) % ENTRIES;
      if (bytes[i] !== 8'(a)) begin
        if (bad == 0) check({tag, "_byte"}, 32'(bytes[i]), 32'(a[7:0]));
        bad++;
      end
    end
    check({tag, "_bad_bytes"}, bad, 0);
  endtask

  initial begin
    bus.dump_start   = 1'b0;
    bus.capture_done = 1'b0;
    bus.waddr_end    = '0;
    step();
    // Reset state.
    check("rst_ren", 32'(bus.ren), 0);
    check("rst_trmt", 32'(bus.trmt), 0);
    check("rst_dumping", 32'(bus.dumping), 0);
    check("rst_raddr", 32'(bus.raddr), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_flags", {30'd0, bus.dump_done, bus.dump_err}, 0);
    rst = 1'b0;
    step();

    // Dump from address 0.
    clear_mon();
    start_dump(9'd0, 0);
    wait_done(10000);
    check_stream("w0", 0);
    check("w0_last", 32'(bytes[$]), 32'h7F);

    // Dump from the last entry: wraps immediately.
    clear_mon();
    start_dump(9'd383, 383);
    wait_done(10000);
    check_stream("w383", 383);
    check("w383_first", 32'(bytes[0]), 32'h7F);
    check("w383_lastb", 32'(bytes[$]), 32'h7E);
    check("w383_a1", 32'(addrs[1]), 0);
    check("w383_alast", 32'(addrs[$]), 382);
    check("w383_naddr", addrs.size(), ENTRIES);

    // Out-of-range end pointer clamps to 0.
    clear_mon();
    start_dump(9'd500, 0);
    wait_done(10000);
    check_stream("w500", 0);

    // Rejected start.
    clear_mon();
    bus.capture_done = 1'b0;
    bus.dump_start   = 1'b1;
    step();
    bus.dump_start   = 1'b0;
    check("err_pulse", 32'(bus.dump_err), 1);
    check("err_ren", 32'(bus.ren), 0);
    check("err_dumping", 32'(bus.dumping), 0);
    step();
    check("err_one_cycle", 32'(bus.dump_err), 0);
    repeat (10) step();
    check("err_count", err_cnt, 1);
    check("err_no_bytes", bytes.size() + addrs.size(), 0);

    // UART stall after the first byte.
    clear_mon();
    start_dump(9'd0, 0);
    wait_bytes(1, 100);
    stall = 1'b1;
    bus.capture_done = 1'b0;   // dropping mid-dump must not abort
    repeat (1000) step();
    check("stall_bytes", bytes.size(), 1);
    check("stall_tx_data", 32'(bus.tx_data), 1);
    check("stall_dumping", 32'(bus.dumping), 1);
    stall = 1'b0;
    wait_done(10000);
    check_stream("stall", 0);

    // Reset mid-dump, then a full dump with ignored mid-dump starts.
    clear_mon();
    start_dump(9'd0, 0);
    wait_bytes(100, 3000);
    rst = 1'b1;
    #1;
    check("mrst_trmt", 32'(bus.trmt), 0);
    check("mrst_ren", 32'(bus.ren), 0);
    check("mrst_dumping", 32'(bus.dumping), 0);
    check("mrst_raddr", 32'(bus.raddr), 0);
    check("mrst_tx_data", 32'(bus.tx_data), 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("mrst_no_more", bytes.size(), 100);
    check("mrst_idle", 32'(bus.dumping), 0);
    clear_mon();
    start_dump(9'd200, 200);
    wait_bytes(50, 3000);
    bus.dump_start = 1'b1; step(); bus.dump_start = 1'b0;
    wait_bytes(200, 5000);
    bus.dump_start = 1'b1; step(); bus.dump_start = 1'b0;
    wait_done(10000);
    check_stream("restart", 200);
    check("restart_no_err", err_cnt, 0);

    // Back-to-back: start the cycle after returning to IDLE.
    clear_mon();
    start_dump(9'd10, 10);
    while (done_cnt == 0 && bytes.size() < 500) step();
    start_dump(9'd20, 20);
    done_cnt = 0;
    bytes.delete();
    wait_done(10000);
    check_stream("b2b", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
